// File: rtl/ofm_mm2s_packer.sv
// -----------------------------------------------------------------------------
// ofm_mm2s_packer
//
// mm2s_clk-domain TX ingress stage. Consumes the AXI DMA MM2S control stream
// (flag word followed by APP0..APP4) and the 64-bit MM2S data stream. Data
// beats are passed straight through into the TX data FIFO as
// {tlast, tkeep, tdata}; once the frame's last beat has been written, a single
// 64-bit frame descriptor is written into the TX ctrl FIFO.
//
// Ports
//   mm2s_clk, mm2s_resetn        clock, async active-low reset
//   s_axis_cntrl_*               32-bit control stream (slave)
//   s_axis_txd_*                 64-bit frame data stream (slave)
//   ctrl_fifo_wdata/wren/afull   descriptor FIFO write side
//                                wdata: [63:32]=APP1, [31]=csum_en,
//                                [30]=len_err, [29:16]=0, [15:0]=byte length
//   data_fifo_wdata/wren/afull   data FIFO write side, {tlast, tkeep, tdata}
// -----------------------------------------------------------------------------
module ofm_mm2s_packer #(
    parameter int C_CTRL_WORDS = 6,
    parameter int C_LEN_W      = 16
) (
    input  logic        mm2s_clk,
    input  logic        mm2s_resetn,

    input  logic [31:0] s_axis_cntrl_tdata,
    input  logic        s_axis_cntrl_tvalid,
    input  logic        s_axis_cntrl_tlast,
    output logic        s_axis_cntrl_tready,

    input  logic [63:0] s_axis_txd_tdata,
    input  logic [7:0]  s_axis_txd_tkeep,
    input  logic        s_axis_txd_tvalid,
    input  logic        s_axis_txd_tlast,
    output logic        s_axis_txd_tready,

    output logic [63:0] ctrl_fifo_wdata,
    output logic        ctrl_fifo_wren,
    input  logic        ctrl_fifo_afull,

    output logic [72:0] data_fifo_wdata,
    output logic        data_fifo_wren,
    input  logic        data_fifo_afull
);

    localparam int C_IDX_W = $clog2(C_CTRL_WORDS);
    localparam logic [C_IDX_W-1:0] C_IDX_APP0 = C_IDX_W'(1);
    localparam logic [C_IDX_W-1:0] C_IDX_APP1 = C_IDX_W'(2);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(C_CTRL_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CTRL,
        ST_DATA,
        ST_DESC
    } state_t;

    // Reset is asserted asynchronously but released on a clock edge, so every
    // state flop leaves reset in the same cycle.
    logic [1:0]         r_rst_sync;
    logic               w_rst_n;

    state_t             r_state;
    state_t             w_next_state;
    logic [C_IDX_W-1:0] r_word_idx;
    logic               r_csum_en;
    logic [31:0]        r_app1;
    logic [C_LEN_W-1:0] r_len;
    logic               r_len_err;

    logic               w_cntrl_hs;
    logic               w_txd_hs;
    logic [3:0]         w_keep_cnt;
    logic [C_LEN_W:0]   w_len_sum;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Handshakes and ready outputs. Readies are decoded from state only, so
    // they drop in the same cycle that reset is asserted.
    assign s_axis_cntrl_tready = (r_state == ST_CTRL);
    assign s_axis_txd_tready   = (r_state == ST_DATA) && !data_fifo_afull;
    assign w_cntrl_hs          = s_axis_cntrl_tvalid && s_axis_cntrl_tready;
    assign w_txd_hs            = s_axis_txd_tvalid && s_axis_txd_tready;

    // Zero-latency pass-through into the data FIFO; wdata is held at zero
    // outside a handshake so the FIFO port is quiet between beats.
    assign data_fifo_wren  = w_txd_hs;
    assign data_fifo_wdata = w_txd_hs ?
        {s_axis_txd_tlast, s_axis_txd_tkeep, s_axis_txd_tdata} : '0;

    assign ctrl_fifo_wren  = (r_state == ST_DESC);
    assign ctrl_fifo_wdata = (r_state == ST_DESC) ?
        {r_app1, r_csum_en, r_len_err, 14'b0, 16'(r_len)} : '0;

    // Byte count of the current beat. tkeep should be contiguous, but a
    // popcount stays correct even if it is not.
    // NOTE: every always_comb output gets a default before any branch so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_keep_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            w_keep_cnt = w_keep_cnt + {3'b000, s_axis_txd_tkeep[i]};
        end
    end

    // One extra bit catches the carry out; that bit drives saturation.
    assign w_len_sum = {1'b0, r_len} + (C_LEN_W + 1)'(w_keep_cnt);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                // Only gate point for the ctrl FIFO: afull leaves room for
                // the single descriptor this frame will write.
                if (!ctrl_fifo_afull) begin
                    w_next_state = ST_CTRL;
                end
            end
            ST_CTRL: begin
                // An early tlast ends the control phase; a missing tlast on
                // the final word is tolerated.
                if (w_cntrl_hs && (s_axis_cntrl_tlast || (r_word_idx == C_IDX_LAST))) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_txd_hs && s_axis_txd_tlast) begin
                    w_next_state = ST_DESC;
                end
            end
            ST_DESC: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge mm2s_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_IDLE;
            r_word_idx <= '0;
            r_csum_en  <= 1'b0;
            r_app1     <= '0;
            r_len      <= '0;
            r_len_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    r_word_idx <= '0;
                end
                ST_CTRL: begin
                    if (w_cntrl_hs) begin
                        r_word_idx <= r_word_idx + 1'b1;
                        if (r_word_idx == C_IDX_APP0) begin
                            r_csum_en <= s_axis_cntrl_tdata[0];
                        end
                        if (r_word_idx == C_IDX_APP1) begin
                            r_app1 <= s_axis_cntrl_tdata;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_txd_hs) begin
                        // Saturate and flag; the frame itself is still
                        // forwarded untouched.
                        if (w_len_sum[C_LEN_W]) begin
                            r_len     <= '1;
                            r_len_err <= 1'b1;
                        end else begin
                            r_len <= w_len_sum[C_LEN_W-1:0];
                        end
                    end
                end
                ST_DESC: begin
                    r_len     <= '0;
                    r_len_err <= 1'b0;
                    r_csum_en <= 1'b0;
                    r_app1    <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
